parity_arbiter: RTL and testbench

Round-robin scheduler that shares one 16-bit parity tree among `N_REQ` requesters. Each requester streams a packet of 16-bit words over a valid/ready handshake. The block folds the parity of every word into a 1-bit accumulator and returns one result per packet: parity, requester id and word count. It sits in front of the combinational 16-input parity datapath, so that datapath is instantiated once rather than per requester.

---
 rtl/parity_arbiter_pkg.sv | 36 +++
 rtl/parity_arbiter_tree.sv | 12 +
 rtl/parity_arbiter.sv | 132 +++++++++++++
 tb/tb_parity_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_arbiter_pkg.sv
// Shared types and helpers for the round-robin parity arbiter.
// Word width, FSM state encoding and the round-robin pick function.
package parity_arbiter_pkg;

    localparam int WORD_W  = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } parity_arb_state_t;

    // First requester at or after ptr with valid set, wrapping modulo n.
    function automatic logic [2:0] rr_next(
        input logic [2:0]         ptr,
        input logic [MAX_REQ-1:0] valid,
        input int                 n
    );
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = 3'((int'(ptr) + i) % n);
            if (!found && (i < n) && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/parity_arbiter_tree.sv
// Purely combinational 16-input XOR reduction shared by all requesters.
// One instance lives in the arbiter, fed by the granted requester's word.
module parity16_tree
    import parity_arbiter_pkg::*;
(
    input  logic [WORD_W-1:0] data,
    output logic              parity
);

    assign parity = ^data;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter that streams packets through one shared parity tree.
// Define PARITY_ARBITER_PIPE_EN to register the tree output (adds a DRAIN state).
module parity_arbiter
    import parity_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WORD_W-1:0]    req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    output logic                       res_parity,
    output logic [CNT_W-1:0]           res_words,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    parity_arb_state_t state_reg, state_next;
    logic [ID_W-1:0]   gnt_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic              acc_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [WORD_W-1:0] words [N_REQ];
    logic [WORD_W-1:0] word_sel;
    logic              word_par;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_evt;
    logic              hs;
    logic              last_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign words[gi]     = req_data[gi*WORD_W +: WORD_W];
            assign req_ready[gi] = (state_reg == STREAM) && (gnt_reg == ID_W'(gi));
        end
    endgenerate

    assign word_sel  = words[gnt_reg];
    assign hs        = (state_reg == STREAM) && req_valid[gnt_reg];
    assign last_sel  = req_last[gnt_reg];
    assign grant_idx = ID_W'(rr_next(3'(ptr_reg), 8'(req_valid), N_REQ));
    assign grant_evt = (state_reg == IDLE) && (|req_valid);

    parity16_tree u_tree (
        .data   (word_sel),
        .parity (word_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (|req_valid) state_next = STREAM;
            end
            STREAM: begin
                if (hs && last_sel) begin
`ifdef PARITY_ARBITER_PIPE_EN
                    state_next = DRAIN;
`else
                    state_next = RESULT;
`endif
                end
            end
            DRAIN:   state_next = RESULT;
            RESULT: begin
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PARITY_ARBITER_PIPE_EN
    logic pipe_valid_reg;
    logic pipe_par_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg <= '0;
            ptr_reg <= '0;
            acc_reg <= 1'b0;
            cnt_reg <= '0;
`ifdef PARITY_ARBITER_PIPE_EN
            pipe_valid_reg <= 1'b0;
            pipe_par_reg   <= 1'b0;
`endif
        end else begin
`ifdef PARITY_ARBITER_PIPE_EN
            // The last word's parity is folded in during DRAIN.
            pipe_valid_reg <= hs;
            pipe_par_reg   <= word_par;
            if (pipe_valid_reg) acc_reg <= acc_reg ^ pipe_par_reg;
`else
            if (hs) acc_reg <= acc_reg ^ word_par;
`endif
            if (hs && (cnt_reg != CNT_MAX)) cnt_reg <= cnt_reg + 1'b1;
            if ((state_reg == RESULT) && res_ready) begin
                ptr_reg <= (gnt_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_reg + 1'b1;
            end
            if (grant_evt) begin
                gnt_reg <= grant_idx;
                acc_reg <= 1'b0;
                cnt_reg <= '0;
            end
        end
    end

    assign res_valid  = (state_reg == RESULT);
    assign busy       = (state_reg != IDLE);
    assign res_id     = gnt_reg;
    assign res_parity = acc_reg;
    assign res_words  = cnt_reg;

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed self-checking bench for parity_arbiter (N_REQ=4, CNT_W=8).
// Build with PARITY_ARBITER_PIPE_EN defined to also exercise the registered tree.
module tb_parity_arbiter;

    localparam int N_REQ = 4;
    localparam int CNT_W = 8;
`ifdef PARITY_ARBITER_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*16-1:0]  req_data;
    logic [N_REQ-1:0]     req_last;
    logic                 res_valid;
    logic                 res_ready;
    logic [1:0]           res_id;
    logic                 res_parity;
    logic [CNT_W-1:0]     res_words;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    parity_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_last   (req_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_parity (res_parity),
        .res_words  (res_words),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int idx, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            ok = req_ready[idx];
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        req_last  = '1;
        res_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({req_ready, res_valid, res_id, res_parity, res_words, busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got rdy=%b vld=%b id=%0d par=%b words=%0d busy=%b, want all 0",
                         c, req_ready, res_valid, res_id, res_parity, res_words, busy);
            end
        end
        rst = 1'b0;
        checks++;
        if ({req_ready, res_valid, res_id, res_parity, res_words, busy} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got rdy=%b vld=%b busy=%b, want all 0", req_ready, res_valid, busy);
        end
        tick();
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant: got rdy=%b busy=%b, want 0001 busy=1", req_ready, busy);
        end
        tick();
        req_valid = '0;
        repeat (EXTRA) tick();
        checks++;
        if (res_valid !== 1'b1 || res_words !== 8'd1 || res_id !== 2'd0 || res_parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_result: got vld=%b words=%0d id=%0d par=%b, want 1/1/0/0",
                     res_valid, res_words, res_id, res_parity);
        end
        $display("reset: result id=%0d parity=%b words=%0d", res_id, res_parity, res_words);
        tick();
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        req_valid[0]    = 1'b1;
        req_data[15:0]  = 16'h0001;
        wait_ready(0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_grant_timeout: got rdy=%b, want 0001", req_ready);
        end
        tick();
        req_data[15:0] = 16'h0003;
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_streaming: got rdy=%b busy=%b, want 0001 busy=1", req_ready, busy);
        end
        tick();
        req_data[15:0] = 16'hFFFF;
        req_last[0]    = 1'b1;
        tick();
        req_valid = '0;
        req_last  = '0;
        repeat (EXTRA) tick();
        checks++;
        if (res_valid !== 1'b1 || res_parity !== 1'b1 || res_words !== 8'd3 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL single_result: got vld=%b par=%b words=%0d id=%0d, want 1/1/3/0",
                     res_valid, res_parity, res_words, res_id);
        end
        $display("single: result id=%0d parity=%b words=%0d", res_id, res_parity, res_words);
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_back_to_idle: got vld=%b busy=%b, want 0/0", res_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] vals [4];
        int          exp_order [5];
        bit          ok;
        bit          multi;
        int          g;
        vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'h0003; vals[3] = 16'h0007;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = vals[i];
        req_last  = '1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            multi = 1'b0;
            for (int n = 0; n < 20 && !ok; n++) begin
                tick();
                if ((req_ready & (req_ready - 4'd1)) != 4'd0) multi = 1'b1;
                ok = (req_ready != 4'd0);
            end
            g = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            checks++;
            if (!ok || multi || g != exp_order[k]) begin
                errors++;
                $display("FAIL rr_grant %0d: got rdy=%b multi=%b, want grant %0d one-hot", k, req_ready, multi, exp_order[k]);
            end
            tick();
            repeat (EXTRA) tick();
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'(exp_order[k]) || res_parity !== ^vals[exp_order[k]]) begin
                errors++;
                $display("FAIL rr_result %0d: got vld=%b id=%0d par=%b, want 1/%0d/%b",
                         k, res_valid, res_id, res_parity, exp_order[k], ^vals[exp_order[k]]);
            end
            $display("round_robin: result id=%0d parity=%b words=%0d", res_id, res_parity, res_words);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        do_reset();
        req_data[16 +: 16] = 16'h0F01;
        req_last[1]        = 1'b1;
        req_valid          = 4'b0110;
        req_last[2]        = 1'b1;
        wait_ready(1, ok);
        checks++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant: got rdy=%b, want 0010", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        repeat (EXTRA) tick();
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (res_valid !== 1'b1 || res_id !== 2'd1 || res_parity !== 1'b1 ||
                res_words !== 8'd1 || req_ready !== 4'd0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_stall_stable: got vld=%b id=%0d par=%b words=%0d rdy=%b, want 1/1/1/1/0000",
                     res_valid, res_id, res_parity, res_words, req_ready);
        end
        $display("backpressure: result id=%0d parity=%b words=%0d", res_id, res_parity, res_words);
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_idle: got vld=%b busy=%b, want 0/0", res_valid, busy);
        end
        tick();
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_next_grant: got rdy=%b, want 0100", req_ready);
        end
    endtask

    task automatic test_gaps_saturation();
        bit ok;
        do_reset();
        req_valid[3]       = 1'b1;
        req_data[48 +: 16] = 16'h0001;
        wait_ready(3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sat_grant_timeout: got rdy=%b, want 1000", req_ready);
        end
        for (int w = 0; w < 300; w++) begin
            if (w % 7 == 3) begin
                req_valid[3] = 1'b0;
                tick();
            end
            req_valid[3] = 1'b1;
            req_last[3]  = (w == 299);
            tick();
        end
        req_valid = '0;
        req_last  = '0;
        repeat (EXTRA) tick();
        checks++;
        if (res_valid !== 1'b1 || res_words !== 8'd255 || res_parity !== 1'b0 || res_id !== 2'd3) begin
            errors++;
            $display("FAIL sat_result: got vld=%b words=%0d par=%b id=%0d, want 1/255/0/3",
                     res_valid, res_words, res_parity, res_id);
        end
        $display("saturation: result id=%0d parity=%b words=%0d", res_id, res_parity, res_words);
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        do_reset();
        req_valid[2]       = 1'b1;
        req_data[32 +: 16] = 16'h0001;
        wait_ready(2, ok);
        repeat (3) tick();
        do_reset();
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'd0) begin
            errors++;
            $display("FAIL midreset_idle: got busy=%b rdy=%b, want 0/0000", busy, req_ready);
        end
        req_valid[2]       = 1'b1;
        req_data[32 +: 16] = 16'h0003;
        wait_ready(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_grant_timeout: got rdy=%b, want 0100", req_ready);
        end
        tick();
        req_data[32 +: 16] = 16'h0010;
        req_last[2]        = 1'b1;
        tick();
        req_valid = '0;
        req_last  = '0;
        repeat (EXTRA) tick();
        checks++;
        if (res_valid !== 1'b1 || res_words !== 8'd2 || res_parity !== 1'b1 || res_id !== 2'd2) begin
            errors++;
            $display("FAIL midreset_result: got vld=%b words=%0d par=%b id=%0d, want 1/2/1/2",
                     res_valid, res_words, res_parity, res_id);
        end
        $display("reset_mid_packet: result id=%0d parity=%b words=%0d", res_id, res_parity, res_words);
    endtask

`ifdef PARITY_ARBITER_PIPE_EN
    task automatic test_pipe();
        bit ok;
        do_reset();
        req_valid[0]   = 1'b1;
        req_last[0]    = 1'b1;
        req_data[15:0] = 16'h8000;
        wait_ready(0, ok);
        tick();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pipe_drain: got vld=%b busy=%b, want 0/1", res_valid, busy);
        end
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_parity !== 1'b1 || res_words !== 8'd1) begin
            errors++;
            $display("FAIL pipe_result: got vld=%b par=%b words=%0d, want 1/1/1", res_valid, res_parity, res_words);
        end
        $display("pipe: result id=%0d parity=%b words=%0d", res_id, res_parity, res_words);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_gaps_saturation();
        test_reset_mid_packet();
`ifdef PARITY_ARBITER_PIPE_EN
        test_pipe();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
